sp_ram_arbiter: RTL

Round-robin arbiter and sequencer sharing one single-port RAM (s_ram: clk, rst, en, addr, data_in, data_out) among NREQ requesters. Accepts one read or write request at a time, drives the RAM port for the required cycles, and returns a per-requester completion pulse with read data. Sits between the requester agents and the s_ram instance. One transaction is in flight at a time.

---
 rtl/sp_ram_arbiter_if.sv | 25 ++
 rtl/sp_ram_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter_if.sv
// Requester-side bus of sp_ram_arbiter: flattened per-requester request fields,
// one-hot grant/completion pulses and shared read data.
interface sp_ram_arbiter_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) ();
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter that serialises requester reads/writes onto one single-port RAM
// with a registered read port; one transaction in flight, all outputs registered.
module sp_ram_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    sp_ram_arbiter_if.slave   bus,
    output logic              busy,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StWr, StRd, StResp} state_e;

    state_e             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   cur;

    logic               found;
    logic [IDX_W-1:0]   win;
    int unsigned        idx;
    logic               win_we;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;
    logic [IDX_W-1:0]   ptr_next;
    logic [NREQ-1:0]    cur_onehot;

    // Scan from ptr upward with wrap-around; first set request wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        win_we     = bus.req_we[win];
        win_addr   = bus.req_addr[32'(win) * ADDR_W +: ADDR_W];
        win_wdata  = bus.req_wdata[32'(win) * DATA_W +: DATA_W];
        ptr_next   = (win == IDX_W'(NREQ - 1)) ? '0 : win + 1'b1;
        cur_onehot = NREQ'(1) << cur;
    end

    // The address goes out on the grant edge so the registered RAM read data is
    // ready to capture on the RESP edge, two cycles after the grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= StIdle;
            ptr           <= '0;
            cur           <= '0;
            bus.gnt       <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            busy          <= 1'b0;
            ram_en        <= 1'b0;
            ram_addr      <= '0;
            ram_din       <= '0;
        end else begin
            bus.gnt       <= '0;
            bus.rsp_valid <= '0;
            unique case (state)
                StIdle: begin
                    ram_en <= 1'b0;
                    busy   <= found;
                    if (found) begin
                        bus.gnt  <= NREQ'(1) << win;
                        cur      <= win;
                        ptr      <= ptr_next;
                        ram_en   <= win_we;
                        ram_addr <= win_addr;
                        if (win_we) begin
                            ram_din <= win_wdata;
                        end
                        state    <= win_we ? StWr : StRd;
                    end
                end
                StWr: begin
                    ram_en        <= 1'b0;
                    bus.rsp_valid <= cur_onehot;
                    busy          <= 1'b0;
                    state         <= StIdle;
                end
                StRd: begin
                    state <= StResp;
                end
                StResp: begin
                    bus.rsp_rdata <= ram_dout;
                    bus.rsp_valid <= cur_onehot;
                    busy          <= 1'b0;
                    state         <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end
endmodule
